program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, PC width in bits (>=4).
REQ-002 Parameter DEPTH, default 4, return-stack entries (power of two, >=2).
REQ-003 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-004 input_clk  in  1  single clock; all state updates on rising edge.
REQ-005 input_reset  in  1  synchronous, active-high reset.
REQ-006 input_enable  in  1  high = execute input_op this cycle; low = hold all state.
REQ-007 input_op  in  3  operation code (see Function).
REQ-008 input_Q  in  WIDTH  jump/call target, or two's-complement branch offset.
REQ-009 output_Q  out  WIDTH  current program counter (registered).
REQ-010 output_stack_full  out  1  return stack holds DEPTH entries.
REQ-011 output_stack_empty  out  1  return stack holds 0 entries.
REQ-012 output_error  out  1  sticky overflow/underflow flag.

Function
REQ-013 All outputs registered; new PC visible on output_Q one cycle after the edge that samples input_op.
REQ-014 input_enable low: PC, stack, error unchanged regardless of input_op.
REQ-015 op 0 HOLD: PC unchanged.
REQ-016 op 1 INC: PC <= PC+1 mod 2^WIDTH; all-ones wraps to 0.
REQ-017 op 2 JUMP: PC <= input_Q.
REQ-018 op 3 BRANCH: PC <= PC + sign-extended input_Q, mod 2^WIDTH, no saturation.
REQ-019 op 4 CALL: push PC+1 (mod 2^WIDTH) onto stack, PC <= input_Q.
REQ-020 op 5 RET: PC <= top of stack, pop.
REQ-021 op 6 SKIP: PC <= PC+2 mod 2^WIDTH.
REQ-022 op 7 reserved: behaves exactly as INC.
REQ-023 CALL while full: PC <= input_Q, push discarded, stack unchanged, output_error set.
REQ-024 RET while empty: PC <= PC+1, stack unchanged, output_error set.
REQ-025 output_error stays set until reset; further ops execute normally.
REQ-026 full/empty reflect stack occupancy after the update, same cycle as output_Q.

Reset
REQ-027 Reset has priority over input_enable and input_op.
REQ-028 Reset values: output_Q = RESET_VECTOR, stack occupancy 0, output_stack_empty = 1, output_stack_full = 0, output_error = 0.
REQ-029 Reset mid-sequence discards all stack contents; no partial push/pop survives.

Configuration
REQ-030 Macro PROGRAM_SEQUENCER_STACK_EN defined: return stack and REQ-019..REQ-024 implemented as stated.
REQ-031 Macro undefined: no stack storage; CALL behaves as JUMP, RET as INC; output_stack_full = 0, output_stack_empty = 1, output_error = 0 constantly.

Structure
REQ-032 Shared package holds opcode constants (OP_HOLD..OP_RSVD) and 3-bit opcode type.
REQ-033 Return stack is one sub-module, program_sequencer_stack (push, pop, data in/out, full, empty, sync reset), instantiated only under the macro.
REQ-034 PC register and next-PC selection live in the top module.

Verification
REQ-035 Reset with RESET_VECTOR=0x10 -> output_Q = 0x10, empty=1, full=0, error=0 next cycle.
REQ-036 From PC=0xFE, INC twice -> 0xFF then 0x00; SKIP from 0xFF -> 0x01; enable low 5 cycles -> PC held.
REQ-037 PC=0x20, BRANCH input_Q=0xFD (-3) -> 0x1D; BRANCH 0x05 -> 0x22; JUMP 0x80 -> 0x80.
REQ-038 PC=0x10 CALL 0x40, then PC=0x40 CALL 0x60, RET, RET -> PCs 0x40, 0x60, 0x41, 0x11; empty=1, error=0.
REQ-039 DEPTH=4: five CALLs -> full=1 after fourth, error=1 after fifth; four RETs return the first four pushes; fifth RET -> PC+1, error stays 1.
REQ-040 Two CALLs then reset asserted one cycle -> output_Q = RESET_VECTOR, empty=1, error=0; following RET -> PC+1, error=1.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module   : program_sequencer_pkg
// Purpose  : Opcode type and opcode constants shared by the program sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package program_sequencer_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_HOLD   = 3'd0;
    localparam opcode_t OP_INC    = 3'd1;
    localparam opcode_t OP_JUMP   = 3'd2;
    localparam opcode_t OP_BRANCH = 3'd3;
    localparam opcode_t OP_CALL   = 3'd4;
    localparam opcode_t OP_RET    = 3'd5;
    localparam opcode_t OP_SKIP   = 3'd6;
    localparam opcode_t OP_RSVD   = 3'd7;

endpackage

`default_nettype wire

// File: rtl/program_sequencer_stack.sv
//------------------------------------------------------------------------------
// Module   : program_sequencer_stack
// Purpose  : LIFO return-address stack; push ignored when full, pop ignored
//            when empty, occupancy cleared by synchronous reset.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module program_sequencer_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    w_top_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (count_q == c_depth);
    assign empty     = (count_q == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign w_top_idx = AW'(count_q - 1'b1);
    assign pop_data  = mem_q[w_top_idx];

    always_comb begin
        count_d = count_q;
        if (w_do_push) begin
            count_d = count_q + 1'b1;
        end else if (w_do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry contents need no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            mem_q[count_q[AW-1:0]] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_sequencer.sv
//------------------------------------------------------------------------------
// Module   : program_sequencer
// Purpose  : Program counter with inc/jump/branch/skip and an optional return
//            stack (CALL/RET), enabled by macro PROGRAM_SEQUENCER_STACK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               DEPTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             input_clk,
    input  logic             input_reset,
    input  logic             input_enable,
    input  logic [2:0]       input_op,
    input  logic [WIDTH-1:0] input_Q,
    output logic [WIDTH-1:0] output_Q,
    output logic             output_stack_full,
    output logic             output_stack_empty,
    output logic             output_error
);

    if (WIDTH < 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("program_sequencer: WIDTH must be >= 4, DEPTH a power of two >= 2");
    end

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_two = WIDTH'(2);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] w_pc_inc;

    assign w_pc_inc = pc_q + c_one;

`ifdef PROGRAM_SEQUENCER_STACK_EN
    logic             error_q, error_d;
    logic             w_push, w_pop;
    logic             w_full, w_empty;
    logic [WIDTH-1:0] w_top;

    program_sequencer_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (input_clk),
        .rst       (input_reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .pop_data  (w_top),
        .full      (w_full),
        .empty     (w_empty)
    );
`endif

    always_comb begin
        pc_d = pc_q;
`ifdef PROGRAM_SEQUENCER_STACK_EN
        error_d = error_q;
        w_push  = 1'b0;
        w_pop   = 1'b0;
`endif
        if (input_enable) begin
            case (input_op)
                OP_HOLD:   pc_d = pc_q;
                OP_INC:    pc_d = w_pc_inc;
                OP_JUMP:   pc_d = input_Q;
                // Same-width add is the two's-complement sign-extended offset.
                OP_BRANCH: pc_d = pc_q + input_Q;
`ifdef PROGRAM_SEQUENCER_STACK_EN
                OP_CALL: begin
                    pc_d = input_Q;
                    if (w_full) begin
                        error_d = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        pc_d    = w_pc_inc;
                        error_d = 1'b1;
                    end else begin
                        pc_d  = w_top;
                        w_pop = 1'b1;
                    end
                end
`else
                OP_CALL:   pc_d = input_Q;
                OP_RET:    pc_d = w_pc_inc;
`endif
                OP_SKIP:   pc_d = pc_q + c_two;
                default:   pc_d = w_pc_inc;
            endcase
        end
    end

    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign output_Q = pc_q;

`ifdef PROGRAM_SEQUENCER_STACK_EN
    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign output_stack_full  = w_full;
    assign output_stack_empty = w_empty;
    assign output_error       = error_q;
`else
    assign output_stack_full  = 1'b0;
    assign output_stack_empty = 1'b1;
    assign output_error       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_program_sequencer
// Purpose  : Self-checking bench: directed scenarios plus random ops against a
//            queue-based reference model of the sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_program_sequencer;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] RV    = 8'h10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [2:0] op  = 3'd0;
    logic [7:0] qin = 8'h00;
    logic [7:0] pc_out;
    logic       full_out, empty_out, err_out;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_pc;
    logic [7:0] m_stack[$];
    logic       m_err;

    program_sequencer #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .input_clk          (clk),
        .input_reset        (rst),
        .input_enable       (en),
        .input_op           (op),
        .input_Q            (qin),
        .output_Q           (pc_out),
        .output_stack_full  (full_out),
        .output_stack_empty (empty_out),
        .output_error       (err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
`ifdef PROGRAM_SEQUENCER_STACK_EN
        check({tag, ".pc"},    32'(pc_out),    32'(m_pc));
        check({tag, ".full"},  32'(full_out),  32'(m_stack.size() == DEPTH));
        check({tag, ".empty"}, 32'(empty_out), 32'(m_stack.size() == 0));
        check({tag, ".err"},   32'(err_out),   32'(m_err));
`else
        check({tag, ".pc"},    32'(pc_out),    32'(m_pc));
        check({tag, ".full"},  32'(full_out),  32'd0);
        check({tag, ".empty"}, 32'(empty_out), 32'd1);
        check({tag, ".err"},   32'(err_out),   32'd0);
`endif
    endtask

    // Reference: behaviour of one enabled op taken straight from the op table.
    task automatic model_step(input logic e, input logic [2:0] o, input logic [7:0] q);
        if (!e) return;
        case (o)
            3'd0: ;
            3'd2: m_pc = q;
            3'd3: m_pc = 8'((int'(m_pc) + int'($signed(q))) & 255);
            3'd4: begin
`ifdef PROGRAM_SEQUENCER_STACK_EN
                if (m_stack.size() == DEPTH) m_err = 1'b1;
                else m_stack.push_back(m_pc + 8'd1);
`endif
                m_pc = q;
            end
            3'd5: begin
`ifdef PROGRAM_SEQUENCER_STACK_EN
                if (m_stack.size() == 0) begin
                    m_pc  = m_pc + 8'd1;
                    m_err = 1'b1;
                end else begin
                    m_pc = m_stack.pop_back();
                end
`else
                m_pc = m_pc + 8'd1;
`endif
            end
            3'd6: m_pc = m_pc + 8'd2;
            default: m_pc = m_pc + 8'd1;
        endcase
    endtask

    task automatic do_op(input string tag, input logic e, input logic [2:0] o, input logic [7:0] q);
        en = e; op = o; qin = q;
        model_step(e, o, q);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        en  = 1'($urandom_range(0, 1));
        op  = 3'($urandom_range(0, 7));
        qin = 8'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = RV;
        m_stack.delete();
        m_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        m_pc  = 8'h00;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset");
        check("reset.vector", 32'(pc_out), 32'h10);

        // Wrap-around and hold
        do_op("jmp_fe", 1'b1, 3'd2, 8'hFE);
        do_op("inc_ff", 1'b1, 3'd1, 8'h00);
        check("inc_ff.lit", 32'(pc_out), 32'hFF);
        do_op("inc_00", 1'b1, 3'd1, 8'h00);
        check("inc_00.lit", 32'(pc_out), 32'h00);
        do_op("jmp_ff", 1'b1, 3'd2, 8'hFF);
        do_op("skip_01", 1'b1, 3'd6, 8'h00);
        check("skip.lit", 32'(pc_out), 32'h01);
        for (int i = 0; i < 5; i++) do_op("hold_en0", 1'b0, 3'($urandom_range(1, 7)), 8'($urandom));
        check("hold.lit", 32'(pc_out), 32'h01);
        do_op("rsvd", 1'b1, 3'd7, 8'h00);
        do_op("op_hold", 1'b1, 3'd0, 8'h55);

        // Branches
        do_op("jmp_20", 1'b1, 3'd2, 8'h20);
        do_op("br_m3", 1'b1, 3'd3, 8'hFD);
        check("br_m3.lit", 32'(pc_out), 32'h1D);
        do_op("br_p5", 1'b1, 3'd3, 8'h05);
        check("br_p5.lit", 32'(pc_out), 32'h22);
        do_op("jmp_80", 1'b1, 3'd2, 8'h80);

        // Nested call/return
        do_op("jmp_10", 1'b1, 3'd2, 8'h10);
        do_op("call_40", 1'b1, 3'd4, 8'h40);
        do_op("call_60", 1'b1, 3'd4, 8'h60);
        do_op("ret_41", 1'b1, 3'd5, 8'h00);
        do_op("ret_11", 1'b1, 3'd5, 8'h00);
`ifdef PROGRAM_SEQUENCER_STACK_EN
        check("ret_11.lit", 32'(pc_out), 32'h11);
`else
        check("ret_inc.lit", 32'(pc_out), 32'h62);
`endif

        // Overflow and underflow
        for (int i = 0; i < 5; i++) do_op("call_ovf", 1'b1, 3'd4, 8'(8'h30 + 8'(i * 16)));
        for (int i = 0; i < 5; i++) do_op("ret_unf", 1'b1, 3'd5, 8'h00);

        // Reset discards stack
        do_reset("reset2");
        do_op("call_a", 1'b1, 3'd4, 8'hA0);
        do_op("call_b", 1'b1, 3'd4, 8'hB0);
        do_reset("reset_mid");
        do_op("ret_after_rst", 1'b1, 3'd5, 8'h00);
        check("ret_after_rst.lit", 32'(pc_out), 32'h11);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset("rnd_reset");
            end else begin
                do_op("rnd", 1'($urandom_range(0, 7) != 0),
                      3'($urandom_range(0, 7)), 8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
